// File: rtl/encoder_round_robin_arbiter.sv
// Round-robin arbiter over 16 requesters, producing a one-hot grant and its 4-bit index.
// A grant is held until the holder releases it, drops its request, or enable falls.
// Each termination moves the priority pointer to the slot just past the old winner.
// Optional feature macro: HOLD_TIMEOUT_EN. When defined, a grant is also cut off after
// MAX_HOLD_CYCLES cycles.
module encoder_round_robin_arbiter #(
    parameter int unsigned INPUT_LENGTH    = 16,
    parameter int unsigned OUTPUT_LENGTH   = 4,
    parameter int unsigned MAX_HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [INPUT_LENGTH-1:0]  input_wire,
    input  logic                     release_wire,
    output logic [INPUT_LENGTH-1:0]  output_wire,
    output logic [OUTPUT_LENGTH-1:0] grant_index,
    output logic                     grant_valid
);

    // Pointer and index wrap by natural overflow, so the request width must be a power of two.
    if (INPUT_LENGTH != (1 << OUTPUT_LENGTH) || MAX_HOLD_CYCLES == 0) begin : g_bad_params
        $error("encoder_round_robin_arbiter: need INPUT_LENGTH == 2**OUTPUT_LENGTH, MAX_HOLD_CYCLES > 0");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                   state_q;
    logic [OUTPUT_LENGTH-1:0] pointer_q;

    logic                     winner_found;
    logic [OUTPUT_LENGTH-1:0] winner_index;
    logic [OUTPUT_LENGTH-1:0] candidate;
    logic                     hold_expired;
    logic                     terminate;

`ifdef HOLD_TIMEOUT_EN
    localparam int unsigned CountWidth = $clog2(MAX_HOLD_CYCLES + 1);
    localparam logic [CountWidth-1:0] HoldLimit = CountWidth'(MAX_HOLD_CYCLES);

    logic [CountWidth-1:0] hold_count_q;

    assign hold_expired = (hold_count_q == HoldLimit);
`else
    assign hold_expired = 1'b0;
`endif

    // The current holder loses the grant on release, request drop, disable or timeout.
    assign terminate = release_wire | ~input_wire[grant_index] | ~enable | hold_expired;

    // Search from the pointer upward with wrap; the first set request bit wins.
    always_comb begin
        winner_found = 1'b0;
        winner_index = '0;
        candidate    = '0;
        for (int unsigned k = 0; k < INPUT_LENGTH; k++) begin
            candidate = pointer_q + OUTPUT_LENGTH'(k);
            if (!winner_found && input_wire[candidate]) begin
                winner_found = 1'b1;
                winner_index = candidate;
            end
        end
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            pointer_q    <= '0;
            output_wire  <= '0;
            grant_index  <= '0;
            grant_valid  <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
            hold_count_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable && winner_found) begin
                        state_q      <= StGrant;
                        output_wire  <= INPUT_LENGTH'(1) << winner_index;
                        grant_index  <= winner_index;
                        grant_valid  <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
                        hold_count_q <= CountWidth'(1);
`endif
                    end
                end
                StGrant: begin
                    if (terminate) begin
                        state_q      <= StIdle;
                        pointer_q    <= grant_index + OUTPUT_LENGTH'(1);
                        output_wire  <= '0;
                        grant_index  <= '0;
                        grant_valid  <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
                        hold_count_q <= '0;
`endif
                    end else begin
`ifdef HOLD_TIMEOUT_EN
                        if (hold_count_q != HoldLimit) begin
                            hold_count_q <= hold_count_q + CountWidth'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_round_robin_arbiter.sv
// Self-checking bench for encoder_round_robin_arbiter: directed vector table, a hold-timeout
// sequence, and randomized traffic compared against a behavioural model.
module tb_encoder_round_robin_arbiter;

    localparam int N        = 16;
    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] input_wire;
    logic        release_wire;
    logic [15:0] output_wire;
    logic [3:0]  grant_index;
    logic        grant_valid;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    bit m_active = 1'b0;
    int m_idx    = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    encoder_round_robin_arbiter #(
        .INPUT_LENGTH   (16),
        .OUTPUT_LENGTH  (4),
        .MAX_HOLD_CYCLES(MAX_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .input_wire  (input_wire),
        .release_wire(release_wire),
        .output_wire (output_wire),
        .grant_index (grant_index),
        .grant_valid (grant_valid)
    );

    typedef struct {
        string       name;
        bit          rst;
        bit          en;
        logic [15:0] req;
        bit          rel;
        logic [15:0] exp_grant;
        logic [3:0]  exp_idx;
        bit          exp_valid;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge, from the rules: who wins, when a grant ends.
    task automatic model_update(input bit r, input bit en, input logic [15:0] req, input bit rel);
        bit term;
        if (r) begin
            m_active = 1'b0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_active) begin
            term = rel || !req[m_idx] || !en;
`ifdef HOLD_TIMEOUT_EN
            if (m_cnt == MAX_HOLD) term = 1'b1;
`endif
            if (term) begin
                m_ptr = (m_idx + 1) % N;
                m_active = 1'b0; m_idx = 0; m_cnt = 0;
            end else if (m_cnt < MAX_HOLD) begin
                m_cnt++;
            end
        end else if (en && req != 16'h0) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_idx = (m_ptr + k) % N;
                    break;
                end
            end
            m_active = 1'b1; m_cnt = 1;
        end
    endtask

    task automatic step(input bit r, input bit en, input logic [15:0] req, input bit rel);
        reset = r; enable = en; input_wire = req; release_wire = rel;
        model_update(r, en, req, rel);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [15:0] eg;
        eg = m_active ? (16'h1 << m_idx) : 16'h0;
        check({tag, " grant"}, 32'(output_wire), 32'(eg));
        check({tag, " index"}, 32'(grant_index), 32'(m_idx));
        check({tag, " valid"}, 32'(grant_valid), 32'(m_active));
    endtask

    initial begin
        int exp_i;
        bit exp_v;
        // name, reset, enable, request, release, expected grant/index/valid
        vecs[0]  = '{"reset_a",      1, 1, 16'hFFFF, 0, 16'h0000, 4'd0,  0};
        vecs[1]  = '{"reset_b",      1, 1, 16'hFFFF, 0, 16'h0000, 4'd0,  0};
        vecs[2]  = '{"grant3",       0, 1, 16'h0028, 0, 16'h0008, 4'd3,  1};
        vecs[3]  = '{"release3",     0, 1, 16'h0028, 1, 16'h0000, 4'd0,  0};
        vecs[4]  = '{"grant5",       0, 1, 16'h0028, 0, 16'h0020, 4'd5,  1};
        vecs[5]  = '{"drop5",        0, 1, 16'h0000, 0, 16'h0000, 4'd0,  0};
        vecs[6]  = '{"grant15",      0, 1, 16'h8000, 0, 16'h8000, 4'd15, 1};
        vecs[7]  = '{"release15",    0, 1, 16'h8000, 1, 16'h0000, 4'd0,  0};
        vecs[8]  = '{"wrap_to0",     0, 1, 16'h8001, 0, 16'h0001, 4'd0,  1};
        vecs[9]  = '{"drop0",        0, 1, 16'h0000, 0, 16'h0000, 4'd0,  0};
        vecs[10] = '{"disabled_a",   0, 0, 16'h0100, 0, 16'h0000, 4'd0,  0};
        vecs[11] = '{"disabled_b",   0, 0, 16'h0100, 0, 16'h0000, 4'd0,  0};
        vecs[12] = '{"enable8",      0, 1, 16'h0100, 0, 16'h0100, 4'd8,  1};
        vecs[13] = '{"disable_mid",  0, 0, 16'h0100, 0, 16'h0000, 4'd0,  0};
        vecs[14] = '{"grant7_wrap",  0, 1, 16'h0080, 0, 16'h0080, 4'd7,  1};
        vecs[15] = '{"reset_mid",    1, 1, 16'h0080, 0, 16'h0000, 4'd0,  0};
        vecs[16] = '{"post_reset0",  0, 1, 16'h0081, 0, 16'h0001, 4'd0,  1};
        vecs[17] = '{"ignore_other", 0, 1, 16'h0083, 0, 16'h0001, 4'd0,  1};
        vecs[18] = '{"drop_last",    0, 1, 16'h0000, 0, 16'h0000, 4'd0,  0};

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].rel);
            check({vecs[i].name, " grant"}, 32'(output_wire), 32'(vecs[i].exp_grant));
            check({vecs[i].name, " index"}, 32'(grant_index), 32'(vecs[i].exp_idx));
            check({vecs[i].name, " valid"}, 32'(grant_valid), 32'(vecs[i].exp_valid));
        end

        // Long hold with requests 1 and 2 pending and no release.
        step(1, 1, 16'h0006, 0);
        for (int c = 0; c < 18; c++) begin
            step(0, 1, 16'h0006, 0);
`ifdef HOLD_TIMEOUT_EN
            if (c < MAX_HOLD)           begin exp_i = 1; exp_v = 1; end
            else if (c == MAX_HOLD)     begin exp_i = 0; exp_v = 0; end
            else if (c < 2 * MAX_HOLD + 1) begin exp_i = 2; exp_v = 1; end
            else                        begin exp_i = 0; exp_v = 0; end
`else
            exp_i = 1; exp_v = 1;
`endif
            check("hold index", 32'(grant_index), 32'(exp_i));
            check("hold valid", 32'(grant_valid), 32'(exp_v));
        end

        // Randomized traffic against the model.
        step(1, 1, 16'h0000, 0);
        check_model("rand_reset");
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(63) == 0), ($urandom_range(7) != 0),
                 16'($urandom & $urandom), ($urandom_range(3) == 0));
            check_model("rand");
            check("rand onehot", 32'($countones(output_wire) <= 1), 32'(1));
            check("rand valid_vs_grant", 32'(grant_valid), 32'(output_wire != 16'h0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
